// File: rtl/ram_block_engine.sv
// Block-transfer engine in front of the 1024x10 RAM: FILL, COPY and SUM over
// a contiguous address range. While busy it owns the RAM write_enable,
// address and data_in lines, all driven from registers.
module ram_block_engine #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [ADDR_W-1:0] length,
  input  logic [DATA_W-1:0] fill_value,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic              ram_write_enable,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_data_in,
  input  logic [DATA_W-1:0] ram_data_out
);

  typedef enum logic [2:0] {
    S_IDLE, S_FILL, S_COPY_RD, S_COPY_WR, S_SUM, S_DONE
  } state_t;

  state_t            state, state_n;
  logic [ADDR_W-1:0] idx, idx_n, idx_inc;
  logic [ADDR_W-1:0] src_q, src_n, dst_q, dst_n, len_q, len_n;
  logic [DATA_W-1:0] fill_q, fill_n, acc, acc_n, result_n;
  logic              we_n;
  logic [ADDR_W-1:0] addr_n;
  logic [DATA_W-1:0] din_n;
  logic              last;

  assign idx_inc = idx + 1'b1;
  // idx is the word currently being accessed; the block ends after word len-1
  assign last    = (idx_inc == len_q);

  assign busy = (state == S_FILL) || (state == S_COPY_RD) ||
                (state == S_COPY_WR) || (state == S_SUM);
  assign done = (state == S_DONE);

  // Next state plus next values of the registered RAM port; the RAM sees the
  // access for word i during the cycle the FSM spends on word i.
  always_comb begin
    state_n  = state;
    idx_n    = idx;
    acc_n    = acc;
    result_n = result;
    src_n    = src_q;
    dst_n    = dst_q;
    len_n    = len_q;
    fill_n   = fill_q;
    we_n     = 1'b0;
    addr_n   = ram_address;
    din_n    = ram_data_in;
    case (state)
      S_IDLE: begin
        if (start) begin
          src_n  = src_addr;
          dst_n  = dst_addr;
          len_n  = length;
          fill_n = fill_value;
          idx_n  = '0;
          acc_n  = '0;
          if (length == '0 || mode == 2'b11) begin
            state_n = S_DONE;
          end else if (mode == 2'b00) begin
            state_n = S_FILL;
            addr_n  = dst_addr;
            din_n   = fill_value;
            we_n    = 1'b1;
          end else if (mode == 2'b01) begin
            state_n = S_COPY_RD;
            addr_n  = src_addr;
          end else begin
            state_n = S_SUM;
            addr_n  = src_addr;
          end
        end
      end
      S_FILL: begin
        if (last) begin
          state_n = S_DONE;
        end else begin
          idx_n  = idx_inc;
          addr_n = dst_q + idx_inc;
          din_n  = fill_q;
          we_n   = 1'b1;
        end
      end
      S_COPY_RD: begin
        // RAM read is combinational, so the source word is valid this cycle
        state_n = S_COPY_WR;
        addr_n  = dst_q + idx;
        din_n   = ram_data_out;
        we_n    = 1'b1;
      end
      S_COPY_WR: begin
        if (last) begin
          state_n = S_DONE;
        end else begin
          state_n = S_COPY_RD;
          idx_n   = idx_inc;
          addr_n  = src_q + idx_inc;
        end
      end
      S_SUM: begin
        acc_n = acc + ram_data_out;
        if (last) begin
          state_n  = S_DONE;
          result_n = acc_n;
        end else begin
          idx_n  = idx_inc;
          addr_n = src_q + idx_inc;
        end
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // State, operands and RAM port registers; reset drops write_enable at once
  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= S_IDLE;
      idx              <= '0;
      acc              <= '0;
      result           <= '0;
      src_q            <= '0;
      dst_q            <= '0;
      len_q            <= '0;
      fill_q           <= '0;
      ram_write_enable <= 1'b0;
      ram_address      <= '0;
      ram_data_in      <= '0;
    end else begin
      state            <= state_n;
      idx              <= idx_n;
      acc              <= acc_n;
      result           <= result_n;
      src_q            <= src_n;
      dst_q            <= dst_n;
      len_q            <= len_n;
      fill_q           <= fill_n;
      ram_write_enable <= we_n;
      ram_address      <= addr_n;
      ram_data_in      <= din_n;
    end
  end

endmodule

// File: tb/tb_ram_block_engine.sv
// Directed bench for ram_block_engine with a behavioural 1024x10 RAM
// (negedge write, combinational read) and hand-computed expectations.
module tb_ram_block_engine;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [1:0] mode;
  logic [9:0] src_addr, dst_addr, length, fill_value;
  logic       busy, done;
  logic [9:0] result;
  logic       ram_write_enable;
  logic [9:0] ram_address, ram_data_in, ram_data_out;

  logic [9:0] mem [1024];
  logic       tb_we;
  logic [9:0] tb_addr, tb_data;

  int nvec = 0, nmis = 0;
  int we_cnt = 0, done_cnt = 0;

  always #5 clk = ~clk;

  ram_block_engine dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode),
    .src_addr(src_addr), .dst_addr(dst_addr), .length(length),
    .fill_value(fill_value), .busy(busy), .done(done), .result(result),
    .ram_write_enable(ram_write_enable), .ram_address(ram_address),
    .ram_data_in(ram_data_in), .ram_data_out(ram_data_out)
  );

  // RAM model; the bench preloads through its own port while the DUT is idle
  always @(negedge clk) begin
    if (ram_write_enable) mem[ram_address] <= ram_data_in;
    else if (tb_we)       mem[tb_addr]     <= tb_data;
  end
  assign ram_data_out = mem[ram_address];

  // Count write strobes and done pulses seen at each edge
  always @(posedge clk) begin
    if (ram_write_enable === 1'b1) we_cnt++;
    if (done === 1'b1)             done_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    if (obs !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk) #1;
  endtask

  task automatic poke(input logic [9:0] a, input logic [9:0] d);
    tb_we = 1'b1; tb_addr = a; tb_data = d;
    step();
    tb_we = 1'b0;
  endtask

  // Leaves the bench in cycle 1 (first access cycle after the accepting edge)
  task automatic do_op(input logic [1:0] m, input logic [9:0] s, input logic [9:0] d,
                       input logic [9:0] n, input logic [9:0] v);
    mode = m; src_addr = s; dst_addr = d; length = n; fill_value = v;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input int k0, output int cyc, output int bc);
    int k;
    k = k0; bc = 0;
    while (done !== 1'b1 && k < 3000) begin
      if (busy === 1'b1) bc++;
      step();
      k++;
    end
    chk("done_seen", done, 1);
    cyc = k;
  endtask

  initial begin
    int cyc, bc, w0, d0;
    reset = 1'b1; start = 1'b0; mode = 2'b00;
    src_addr = '0; dst_addr = '0; length = '0; fill_value = '0;
    tb_we = 1'b0; tb_addr = '0; tb_data = '0;
    repeat (3) step();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_result", result, 0);
    chk("rst_we", ram_write_enable, 0);
    chk("rst_addr", ram_address, 0);
    chk("rst_din", ram_data_in, 0);
    reset = 1'b0;
    step();

    // FILL with address wrap
    poke(10'h002, 10'h123); poke(10'h3FD, 10'h111);
    w0 = we_cnt;
    do_op(2'b00, 10'h000, 10'h3FE, 10'd4, 10'h2AA);
    wait_done(1, cyc, bc);
    chk("fill_done_cyc", cyc, 5);
    chk("fill_busy_cyc", bc, 4);
    chk("fill_we_cnt", we_cnt - w0, 4);
    step();
    chk("fill_done_1cyc", done, 0);
    chk("fill_3fe", mem[10'h3FE], 10'h2AA);
    chk("fill_3ff", mem[10'h3FF], 10'h2AA);
    chk("fill_000", mem[10'h000], 10'h2AA);
    chk("fill_001", mem[10'h001], 10'h2AA);
    chk("fill_002", mem[10'h002], 10'h123);
    chk("fill_3fd", mem[10'h3FD], 10'h111);

    // COPY
    poke(10'h010, 10'd1); poke(10'h011, 10'd2); poke(10'h012, 10'd3);
    poke(10'h100, 10'd0); poke(10'h101, 10'd0); poke(10'h102, 10'd0); poke(10'h103, 10'h0F0);
    w0 = we_cnt;
    do_op(2'b01, 10'h010, 10'h100, 10'd3, 10'h000);
    wait_done(1, cyc, bc);
    chk("copy_done_cyc", cyc, 7);
    chk("copy_busy_cyc", bc, 6);
    chk("copy_we_cnt", we_cnt - w0, 3);
    step();
    chk("copy_100", mem[10'h100], 10'd1);
    chk("copy_101", mem[10'h101], 10'd2);
    chk("copy_102", mem[10'h102], 10'd3);
    chk("copy_103", mem[10'h103], 10'h0F0);

    // SUM with checksum wrap
    poke(10'h020, 10'h3FF); poke(10'h021, 10'h002); poke(10'h022, 10'h005);
    w0 = we_cnt;
    do_op(2'b10, 10'h020, 10'h000, 10'd3, 10'h000);
    wait_done(1, cyc, bc);
    chk("sum_done_cyc", cyc, 4);
    chk("sum_busy_cyc", bc, 3);
    chk("sum_result", result, 10'h006);
    chk("sum_we_cnt", we_cnt - w0, 0);
    repeat (3) step();
    chk("sum_hold", result, 10'h006);

    // length 0 and reserved mode: no access, done next cycle
    w0 = we_cnt;
    do_op(2'b00, 10'h000, 10'h050, 10'd0, 10'h3FF);
    wait_done(1, cyc, bc);
    chk("len0_done_cyc", cyc, 1);
    chk("len0_busy_cyc", bc, 0);
    step();
    do_op(2'b11, 10'h000, 10'h050, 10'd5, 10'h3FF);
    wait_done(1, cyc, bc);
    chk("rsv_done_cyc", cyc, 1);
    chk("rsv_busy_cyc", bc, 0);
    chk("noacc_we_cnt", we_cnt - w0, 0);
    chk("noacc_result_hold", result, 10'h006);
    step();

    // start during a busy FILL is dropped
    poke(10'h310, 10'h000); poke(10'h311, 10'h000);
    w0 = we_cnt; d0 = done_cnt;
    do_op(2'b00, 10'h000, 10'h300, 10'd6, 10'h155);
    repeat (2) step();
    mode = 2'b00; dst_addr = 10'h310; length = 10'd2; fill_value = 10'h0AA;
    start = 1'b1;
    step();
    start = 1'b0;
    wait_done(4, cyc, bc);
    chk("ign_done_cyc", cyc, 7);
    repeat (12) step();
    chk("ign_done_pulses", done_cnt - d0, 1);
    chk("ign_we_cnt", we_cnt - w0, 6);
    chk("ign_305", mem[10'h305], 10'h155);
    chk("ign_310", mem[10'h310], 10'h000);

    // reset in the middle of an 8-word COPY, after 3 words landed
    for (int j = 0; j < 8; j++) begin
      poke(10'h040 + 10'(j), 10'h031 + 10'(j));
      poke(10'h200 + 10'(j), 10'h000);
    end
    w0 = we_cnt; d0 = done_cnt;
    do_op(2'b01, 10'h040, 10'h200, 10'd8, 10'h000);
    repeat (6) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mrst_we", ram_write_enable, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_result", result, 0);
    repeat (15) step();
    chk("mrst_done_pulses", done_cnt - d0, 0);
    chk("mrst_we_cnt", we_cnt - w0, 3);
    chk("mrst_200", mem[10'h200], 10'h031);
    chk("mrst_202", mem[10'h202], 10'h033);
    chk("mrst_203", mem[10'h203], 10'h000);
    chk("mrst_207", mem[10'h207], 10'h000);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
